// File: rtl/display_scan_controller.sv
// display_scan_controller
//
// Drives a four-digit, time-multiplexed seven-segment display from a binary
// millisecond count. A captured value is clamped, then converted to four BCD
// digits by an iterative shift-and-add-3 (double dabble) engine that takes
// one clock per input bit. The finished digits are committed to the display
// registers in a single cycle, so a half-converted number is never shown.
// Independently, a free-running scan scheduler steps through the four digit
// positions and presents one digit at a time to the shared segment decoder.
//
// Parameters:
//   REFRESH_DIV  clock cycles each digit is held before the scan advances (>= 2)
//   MAX_VALUE    ceiling applied to the captured value before conversion
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   value         binary millisecond count to display
//   load          one-cycle request to capture value and start a conversion
//   show_error    level; show the error code on every digit
//   blank         level; turn all anodes off
//   busy          high while a conversion is in progress
//   digit_value   BCD digit (or error code) for the active digit
//   digit_select  index of the active digit, 0 = rightmost
//   an            active-low anode enables, an[i] drives digit i

module display_scan_controller #(
    parameter int REFRESH_DIV = 50000,
    parameter int MAX_VALUE   = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] value,
    input  logic        load,
    input  logic        show_error,
    input  logic        blank,
    output logic        busy,
    output logic [3:0]  digit_value,
    output logic [1:0]  digit_select,
    output logic [3:0]  an
);

    localparam int              DIV_W     = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [13:0]     CLAMP     = 14'(MAX_VALUE);
    localparam logic [3:0]      BIT_LAST  = 4'd13;
    localparam logic [3:0]      ERR_CODE  = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [3:0]         bit_cnt;
    logic [13:0]        bin_sr;
    logic [15:0]        bcd_sr;
    logic [15:0]        digit_reg;
    logic [DIV_W-1:0]   divider;

    // Combinational selection feeding the registered display outputs
    logic [3:0]         value_p0;
    logic [3:0]         an_p0;
    logic [3:0]         active_an;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic [13:0] clamp_value(input logic [13:0] v);
        return (v > CLAMP) ? CLAMP : v;
    endfunction

    // Double-dabble correction: any BCD nibble of 5 or more would exceed 9
    // after the next doubling, so bias it by 3 to force the carry.
    function automatic logic [15:0] add3_nibbles(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Position of the most significant nonzero digit; 0 when all digits are
    // zero so that the rightmost digit still lights and shows "0".
    function automatic logic [1:0] top_digit(input logic [15:0] d);
        logic [1:0] t;
        t = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (d[4*i +: 4] != 4'd0) begin
                t = 2'(i);
            end
        end
        return t;
    endfunction

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == BIT_LAST) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Conversion datapath: shift registers carry no reset, the FSM gates
    // every use of their contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == IDLE && load) begin
            bin_sr <= clamp_value(value);
            bcd_sr <= 16'd0;
        end else if (state == SHIFT) begin
            {bcd_sr, bin_sr} <= {add3_nibbles(bcd_sr), bin_sr} << 1;
        end
    end

    // Shift counter and committed digit registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= 4'd0;
            digit_reg <= 16'd0;
        end else begin
            if (state == SHIFT) begin
                bit_cnt <= bit_cnt + 4'd1;
            end else begin
                bit_cnt <= 4'd0;
            end
            if (state == COMMIT) begin
                digit_reg <= bcd_sr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan scheduler
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divider      <= '0;
            digit_select <= 2'd0;
        end else if (divider == DIV_LAST) begin
            divider      <= '0;
            digit_select <= digit_select + 2'd1;
        end else begin
            divider <= divider + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Display selection: blank overrides error, error overrides number
    // ------------------------------------------------------------------
    always_comb begin
        case (digit_select)
            2'd0:    active_an = 4'b1110;
            2'd1:    active_an = 4'b1101;
            2'd2:    active_an = 4'b1011;
            default: active_an = 4'b0111;
        endcase

        value_p0 = digit_reg[{digit_select, 2'b00} +: 4];
        an_p0    = (digit_select <= top_digit(digit_reg)) ? active_an : 4'b1111;

        if (show_error) begin
            value_p0 = ERR_CODE;
            an_p0    = active_an;
        end
        if (blank) begin
            value_p0 = 4'd0;
            an_p0    = 4'b1111;
        end
    end

    // Registered display outputs, one cycle behind digit_select
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_value <= 4'd0;
            an          <= 4'b1111;
        end else begin
            digit_value <= value_p0;
            an          <= an_p0;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Testbench for display_scan_controller (REFRESH_DIV = 4).
// Directed steps plus randomized loads and mode changes, checked each cycle
// against a decimal-arithmetic reference model.

module tb_display_scan_controller;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] value;
    logic        load;
    logic        show_error;
    logic        blank;
    logic        busy;
    logic [3:0]  digit_value;
    logic [1:0]  digit_select;
    logic [3:0]  an;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    display_scan_controller #(
        .REFRESH_DIV(R),
        .MAX_VALUE(9999)
    ) dut (
        .clk(clk),
        .reset(reset),
        .value(value),
        .load(load),
        .show_error(show_error),
        .blank(blank),
        .busy(busy),
        .digit_value(digit_value),
        .digit_select(digit_select),
        .an(an)
    );

    // ------------------------------------------------------------------
    // Reference model: decimal digits of the shown number, scan position
    // derived from the number of clock edges since reset.
    // ------------------------------------------------------------------
    int         m_k;      // edges since reset released
    int         m_val;    // number currently in the display registers
    int         m_pend;   // clamped number being converted
    int         m_cnt;    // remaining busy cycles
    logic [3:0] m_dv;
    logic [3:0] m_an;

    function automatic int dec_digit(input int v, input int i);
        int t;
        t = v;
        for (int j = 0; j < i; j++) t = t / 10;
        return t % 10;
    endfunction

    function automatic int num_digits(input int v);
        if (v >= 1000) return 4;
        if (v >= 100)  return 3;
        if (v >= 10)   return 2;
        return 1;
    endfunction

    function automatic logic [3:0] exp_dv(input int v, input int s, input logic b, input logic e);
        if (b) return 4'd0;
        if (e) return 4'hE;
        return 4'(dec_digit(v, s));
    endfunction

    function automatic logic [3:0] exp_an(input int v, input int s, input logic b, input logic e);
        logic [3:0] one;
        one = 4'b0001;
        if (b) return 4'hF;
        if (e || s < num_digits(v)) return ~(one << s);
        return 4'hF;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_k    <= 0;
            m_val  <= 0;
            m_pend <= 0;
            m_cnt  <= 0;
            m_dv   <= 4'd0;
            m_an   <= 4'hF;
        end else begin
            m_dv <= exp_dv(m_val, (m_k / R) % 4, blank, show_error);
            m_an <= exp_an(m_val, (m_k / R) % 4, blank, show_error);
            m_k  <= m_k + 1;
            if (m_cnt == 0) begin
                if (load) begin
                    m_cnt  <= 15;
                    m_pend <= (int'(value) > 9999) ? 9999 : int'(value);
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) m_val <= m_pend;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic tick();
        @(negedge clk);
        chk("busy", 32'(busy), 32'(m_cnt != 0));
        chk("digit_select", 32'(digit_select), 32'((m_k / R) % 4));
        chk("digit_value", 32'(digit_value), 32'(m_dv));
        chk("an", 32'(an), 32'(m_an));
        chk("an_single_low", 32'($countones(~an) <= 1), 32'd1);
    endtask

    logic [3:0] rec_dv [4];
    logic [3:0] rec_lit;

    // Observe one full scan and record what each lit position showed.
    task automatic scan_record();
        rec_lit = 4'd0;
        for (int i = 0; i < 4; i++) rec_dv[i] = 4'd0;
        for (int c = 0; c < 4 * R; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (an[i] == 1'b0) begin
                    rec_lit[i] = 1'b1;
                    rec_dv[i]  = digit_value;
                end
            end
        end
    endtask

    task automatic expect_shown(input string tag, input logic [15:0] digs, input logic [3:0] mask);
        scan_record();
        chk({tag, "_lit"}, 32'(rec_lit), 32'(mask));
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) chk({tag, "_digit"}, 32'(rec_dv[i]), 32'(digs[4*i +: 4]));
        end
    endtask

    // Start a conversion and count busy cycles; optionally pulse a second
    // load at busy cycle inject_at.
    task automatic convert(input logic [13:0] v, input int inject_at,
                           input logic [13:0] inj, output int n);
        int guard;
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        n     = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            n++;
            if (n == inject_at) begin
                load  = 1'b1;
                value = inj;
            end else begin
                load = 1'b0;
            end
            tick();
            guard++;
        end
        load = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed and randomized steps
    // ------------------------------------------------------------------
    initial begin
        int n;
        logic [13:0] rv;

        reset      = 1'b1;
        load       = 1'b0;
        value      = 14'd0;
        show_error = 1'b0;
        blank      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_digit_value", 32'(digit_value), 32'd0);
        chk("rst_digit_select", 32'(digit_select), 32'd0);
        reset = 1'b0;

        expect_shown("idle_zero", 16'h0000, 4'b0001);

        convert(14'd1234, 0, 14'd0, n);
        chk("busy_len_1234", 32'(n), 32'd15);
        expect_shown("show_1234", 16'h1234, 4'b1111);

        convert(14'd10000, 0, 14'd0, n);
        chk("busy_len_10000", 32'(n), 32'd15);
        expect_shown("clamp_10000", 16'h9999, 4'b1111);

        convert(14'd16383, 0, 14'd0, n);
        expect_shown("clamp_16383", 16'h9999, 4'b1111);

        convert(14'd7, 0, 14'd0, n);
        expect_shown("show_7", 16'h0007, 4'b0001);

        convert(14'd0, 0, 14'd0, n);
        expect_shown("show_0", 16'h0000, 4'b0001);

        convert(14'd5678, 5, 14'd42, n);
        chk("busy_len_ignored_load", 32'(n), 32'd15);
        expect_shown("show_5678", 16'h5678, 4'b1111);

        show_error = 1'b1;
        scan_record();
        chk("error_lit", 32'(rec_lit), 32'hF);
        for (int i = 0; i < 4; i++) chk("error_code", 32'(rec_dv[i]), 32'hE);

        blank = 1'b1;
        scan_record();
        chk("blank_lit", 32'(rec_lit), 32'h0);

        blank      = 1'b0;
        show_error = 1'b0;
        expect_shown("restore_5678", 16'h5678, 4'b1111);

        for (int t = 0; t < 6; t++) begin
            rv = 14'($urandom_range(0, 16383));
            convert(rv, 0, 14'd0, n);
            chk("busy_len_random", 32'(n), 32'd15);
            for (int c = 0; c < 24; c++) begin
                blank      = ($urandom_range(0, 3) == 0);
                show_error = ($urandom_range(0, 3) == 0);
                tick();
            end
            blank      = 1'b0;
            show_error = 1'b0;
            repeat (4 * R) tick();
        end

        value = 14'd9999;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_an", 32'(an), 32'hF);
        chk("abort_digit_value", 32'(digit_value), 32'd0);
        chk("abort_digit_select", 32'(digit_select), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) tick();
        chk("abort_idle", 32'(busy), 32'd0);
        expect_shown("abort_zero", 16'h0000, 4'b0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Sequences the shared seven-segment decoder across the four display digits. Converts the 14-bit millisecond result from the timer into four BCD digits with an iterative shift-and-add-3 engine. Time-multiplexes the digits onto the single decoder and anode bus, and supplies the value_to_display and current_digit signals to seg7_driver. Sits between the timer/FSM outputs and the display.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit is held before advancing the scan (>=2)
MAX_VALUE, 9999, clamp ceiling applied to the input before conversion

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
value  input  14  binary millisecond count to display
load  input  1  one-cycle request to capture value and start a conversion
show_error  input  1  level; display error pattern instead of the number
blank  input  1  level; all anodes off
busy  output  1  high while a conversion is in progress
digit_value  output  4  BCD/code for the active digit, to seg7_driver value
digit_select  output  2  index of the active digit (0 = rightmost), to seg7_driver digit_select
an  output  4  active-low anode enables, an[i] drives digit i

Behaviour:
- Reset (async, active-high): busy=0, digit_value=0, digit_select=0, an=4'b1111, divider=0, all four digit registers=0, FSM=IDLE.
- Conversion FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on load=1, latch min(value, MAX_VALUE) into the shift register, clear the BCD scratch, and go to SHIFT. busy=1 from the next cycle.
  - SHIFT: runs exactly 14 cycles. Each cycle adds 3 to any BCD nibble >=5, then shifts left one bit, taking in the binary MSB.
  - COMMIT: copies all four scratch nibbles to the display digit registers in one cycle (atomic, no partial update is ever shown), then returns to IDLE. busy=0 in the cycle the FSM is back in IDLE.
  - Latency: load sampled at edge N -> busy high N+1..N+15 -> new digits visible from edge N+16.
  - load while busy=1 is ignored (not queued).
  - load and reset together: reset wins.
- Scan scheduler (runs continuously, independent of conversion):
  - The divider counts 0..REFRESH_DIV-1.
  - At the terminal count the divider wraps to 0 and digit_select increments, wrapping 3->0.
  - digit_value and an are registered and follow digit_select with 1-cycle latency.
- Display selection, in priority order:
  1. blank=1: an=4'b1111, digit_value=0.
  2. show_error=1: digit_value=4'hE for every digit, and the active digit's anode is low.
  3. Number mode: digit_value = the digit register at digit_select. Leading-zero suppression applies: a digit above the most significant nonzero digit keeps its anode high. Digit 0 is always lit, so a value of 0 shows "0".
- an never has more than one bit low.
- Clamp: value > MAX_VALUE converts MAX_VALUE. Values up to 16383 are handled without overflow.
- Reset mid-conversion aborts it and the digits read 0.
- blank and show_error changes take effect at the next scan register update, without waiting for a digit boundary.

Test Plan:
- REFRESH_DIV=4, load value=1234 -> busy high for exactly 15 cycles. Across one full scan, digit_select 0,1,2,3 yields digit_value 4,3,2,1 with an 1110,1101,1011,0111, each held 4 cycles.
- load value=10000, then separately value=16383 -> displayed digits 9,9,9,9 in both cases.
- load value=7 -> only an=1110 ever goes low, with digit_value=7. load value=0 -> an=1110 with digit_value=0. Digits 1-3 stay dark.
- load value=5678, then pulse load value=42 at busy cycle 5 -> second load ignored, display shows 5678, busy drops at cycle 15.
- show_error=1 -> digit_value=E on every scan slot with a single anode low. Then blank=1 -> an=1111. Releasing both restores the prior number.
- Assert reset in SHIFT cycle 7 of a conversion of 9999 -> outputs immediately at their reset values. After release, displays "0" and busy=0.
